jk_cmd_sequencer: RTL and testbench

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

---
 rtl/jk_pkg.sv | 25 ++
 rtl/jk_cmd_fifo.sv | 50 +++++
 rtl/jk_cmd_sequencer.sv | 108 ++++++++++
 tb/tb_jk_cmd_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared encodings for the JK command sequencer: operation codes, FSM states
// and helpers that map an operation onto the J/K drive pins.
package jk_pkg;

   localparam int unsigned OP_W = 2;

   typedef logic [OP_W-1:0] jk_op_t;

   localparam jk_op_t OP_HOLD = 2'b00;
   localparam jk_op_t OP_CLR  = 2'b01;
   localparam jk_op_t OP_SET  = 2'b10;
   localparam jk_op_t OP_TGL  = 2'b11;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;

   function automatic logic op_j(input jk_op_t op);
      return op[1];
   endfunction

   function automatic logic op_k(input jk_op_t op);
      return op[0];
   endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command queue for the JK sequencer: power-of-two depth, first-word
// fall-through read, registered occupancy count.
module jk_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 6,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues {op, len} commands and plays each onto registered J/K drives for
// len+1 cycles, back-to-back with no bubble between queued commands.
module jk_cmd_sequencer
   import jk_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LEN_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [LEN_W-1:0]         cmd_len,
   output logic                     J,
   output logic                     K,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned CMD_W = OP_W + LEN_W;

   logic [0:0]       state_q, state_d;
   jk_op_t           op_q, op_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             j_q, j_d, k_q, k_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             ready_q, ready_d;

   logic             push, pop, last_c, drive_c;
   logic [CMD_W-1:0] fifo_dout;
   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_cnt;

   assign push   = cmd_valid && ready_q && !fifo_full;
   assign last_c = (state_q == ST_DRIVE) && (len_q == '0);
   assign pop    = !fifo_empty && ((state_q == ST_IDLE) || last_c);

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  ({cmd_op, cmd_len}),
      .pop_i   (pop),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   // Next state plus output values derived from it, so every output is a flop.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      len_d   = len_q;
      drive_c = 1'b0;
      if (pop) begin
         state_d = ST_DRIVE;
         op_d    = fifo_dout[CMD_W-1:LEN_W];
         len_d   = fifo_dout[LEN_W-1:0];
      end else if (state_q == ST_DRIVE) begin
         if (len_q == '0) state_d = ST_IDLE;
         else             len_d   = len_q - LEN_W'(1);
      end
      drive_c = (state_d == ST_DRIVE);
      j_d     = drive_c && op_j(op_d);
      k_d     = drive_c && op_k(op_d);
      busy_d  = drive_c;
      done_d  = drive_c && (len_d == '0);
      ready_d = (fifo_cnt + CNT_W'(push) - CNT_W'(pop)) != CNT_W'(DEPTH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         len_q   <= '0;
         j_q     <= 1'b0;
         k_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         len_q   <= len_d;
         j_q     <= j_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign J          = j_q;
   assign K          = k_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cmd_ready  = ready_q;
   assign fifo_count = fifo_cnt;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Randomized and directed bench for jk_cmd_sequencer against a queue-based
// reference model of the command stream.
module tb_jk_cmd_sequencer;
   import jk_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LEN_W = 4;

   typedef struct packed {
      logic [1:0]       op;
      logic [LEN_W-1:0] len;
   } cmd_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [LEN_W-1:0] cmd_len;
   logic             J, K, busy, done;
   logic [2:0]       fifo_count;
   logic             q_ff;

   int   n_checks = 0;
   int   n_errors = 0;

   // reference model: pending queue, current command, cycles left in it
   cmd_t mq[$];
   cmd_t cur;
   int   rem;
   bit   rdy_m;

   jk_cmd_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_len    (cmd_len),
      .J          (J),
      .K          (K),
      .busy       (busy),
      .done       (done),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   // downstream JK flip-flop driven by the sequencer
   always @(posedge clk or posedge reset) begin
      if (reset) q_ff <= 1'b0;
      else begin
         case ({J, K})
            2'b10:   q_ff <= 1'b1;
            2'b01:   q_ff <= 1'b0;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      rem   = 0;
      cur   = '0;
      rdy_m = 1'b0;
   endtask

   task automatic drive(input bit v, input logic [1:0] op, input int len);
      cmd_valid = v;
      cmd_op    = op;
      cmd_len   = LEN_W'(len);
   endtask

   // one clock: advance the model with the inputs present at the edge, then compare
   task automatic step();
      bit   push;
      cmd_t c;
      @(posedge clk);
      push = cmd_valid && rdy_m;
      if (rem <= 1) begin
         if (mq.size() > 0) begin
            cur = mq.pop_front();
            rem = int'(cur.len) + 1;
         end else begin
            rem = 0;
         end
      end else begin
         rem--;
      end
      if (push) begin
         c.op  = cmd_op;
         c.len = cmd_len;
         mq.push_back(c);
      end
      rdy_m = (mq.size() != DEPTH);
      #1;
      check("J",          32'(J),          32'((rem > 0) && cur.op[1]));
      check("K",          32'(K),          32'((rem > 0) && cur.op[0]));
      check("busy",       32'(busy),       32'(rem > 0));
      check("done",       32'(done),       32'(rem == 1));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("cmd_ready",  32'(cmd_ready),  32'(rdy_m));
   endtask

   task automatic drain();
      int n = 0;
      drive(0, 2'b00, 0);
      do begin
         step();
         n++;
      end while ((busy || fifo_count != 0) && n < 300);
      check("drain_timeout", 32'(n >= 300), 32'(0));
   endtask

   initial begin
      int        jc, dc, bc, qi;
      bit        prev_done, saw_full;
      int        accepted;
      logic [1:0] seq_op [4];
      logic       seq_q  [4];

      reset = 1'b1;
      drive(0, 2'b00, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_J",     32'(J),          32'(0));
      check("rst_K",     32'(K),          32'(0));
      check("rst_busy",  32'(busy),       32'(0));
      check("rst_done",  32'(done),       32'(0));
      check("rst_count", 32'(fifo_count), 32'(0));
      check("rst_ready", 32'(cmd_ready),  32'(0));
      reset = 1'b0;
      step();
      check("ready_after_rst", 32'(cmd_ready), 32'(1));

      // single set command, len 2
      drive(1, OP_SET, 2);
      step();
      drive(0, 2'b00, 0);
      jc = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (J && !K) jc++;
      end
      check("set_len2_cycles", 32'(jc), 32'(3));
      drain();

      // back-to-back commands, no gap
      drive(1, OP_TGL, 0); step();
      drive(1, OP_CLR, 1); step();
      drive(1, OP_SET, 0); step();
      drain();

      // fill the queue behind a long command
      drive(1, OP_TGL, 15); step();
      accepted = 0;
      saw_full = 1'b0;
      for (int i = 0; i < 100 && accepted < 5; i++) begin
         bit take;
         take = rdy_m;
         drive(1, 2'(i), i % 3);
         step();
         if (take) accepted++;
         if (fifo_count == 3'd4 && !cmd_ready) saw_full = 1'b1;
      end
      check("full_accepts", 32'(accepted), 32'(5));
      check("full_seen",    32'(saw_full), 32'(1));
      drain();

      // asynchronous reset in the middle of a drive
      drive(1, OP_TGL, 7); step();
      drive(1, OP_CLR, 1); step();
      drive(1, OP_SET, 2); step();
      drive(0, 2'b00, 0);
      step(); step();
      #1 reset = 1'b1;
      #1;
      check("arst_J",     32'(J),          32'(0));
      check("arst_K",     32'(K),          32'(0));
      check("arst_busy",  32'(busy),       32'(0));
      check("arst_count", 32'(fifo_count), 32'(0));
      check("arst_ready", 32'(cmd_ready),  32'(0));
      #2 reset = 1'b0;
      model_reset();
      bc = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (busy || J || K) bc++;
      end
      check("arst_quiet", 32'(bc), 32'(0));

      // hold occupies its cycles with J=K=0
      drive(1, OP_HOLD, 3); step();
      drive(0, 2'b00, 0);
      bc = 0; dc = 0;
      for (int i = 0; i < 7; i++) begin
         step();
         if (busy && !J && !K) bc++;
         if (done) dc++;
      end
      check("hold_busy", 32'(bc), 32'(4));
      check("hold_done", 32'(dc), 32'(1));
      drain();

      // downstream flip-flop sees set, toggle, toggle, clear
      seq_op[0] = OP_SET; seq_op[1] = OP_TGL; seq_op[2] = OP_TGL; seq_op[3] = OP_CLR;
      seq_q[0]  = 1'b1;   seq_q[1]  = 1'b0;   seq_q[2]  = 1'b1;   seq_q[3]  = 1'b0;
      qi = 0;
      prev_done = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i < 4) drive(1, seq_op[i], 0);
         else       drive(0, 2'b00, 0);
         step();
         if (prev_done && qi < 4) begin
            check($sformatf("jkff_q%0d", qi), 32'(q_ff), 32'(seq_q[qi]));
            qi++;
         end
         prev_done = done;
      end
      check("jkff_count", 32'(qi), 32'(4));
      drain();

      // maximum length: 16 cycles, no counter wrap
      drive(1, OP_SET, 15); step();
      drive(0, 2'b00, 0);
      jc = 0; dc = 0;
      for (int i = 0; i < 22; i++) begin
         step();
         if (J) jc++;
         if (done) dc++;
      end
      check("maxlen_cycles", 32'(jc), 32'(16));
      check("maxlen_done",   32'(dc), 32'(1));

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3));
         step();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
